// File: rtl/sleepy_spi_pkg.sv
// -----------------------------------------------------------------------------
// sleepy_spi_pkg
// Shared definitions for the SPI link into the synthesizer's register bank:
// frame width, register map, CONTROL register bit positions, the writer FSM
// state encoding and a counter-width helper.
// -----------------------------------------------------------------------------
package sleepy_spi_pkg;

  // One frame = 8-bit address followed by 8-bit data, MSB first.
  localparam int FRAME_W = 16;

  // Register map (address bits [2:0]; bits [7:3] are always 0).
  localparam logic [7:0] REG_CONTROL       = 8'd0;
  localparam logic [7:0] REG_FREQ_LOW      = 8'd1;
  localparam logic [7:0] REG_FREQ_MID      = 8'd2;
  localparam logic [7:0] REG_FREQ_HIGH     = 8'd3;
  localparam logic [7:0] REG_DUTY          = 8'd4;
  localparam logic [7:0] REG_VOLUME        = 8'd5;
  localparam logic [7:0] REG_STREAM_SAMPLE = 8'd6;
  localparam logic [7:0] REG_STATUS        = 8'd7;

  // CONTROL register bit positions.
  localparam int CTRL_OSC_EN      = 0;
  localparam int CTRL_STREAM_MODE = 1;
  localparam int CTRL_SW_GATE     = 2;
  localparam int CTRL_SQUARE_EN   = 3;
  localparam int CTRL_SAW_EN      = 4;
  localparam int CTRL_TRI_EN      = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } spi_state_t;

  // Width of a down-counter preloaded with (n - 1), for the largest n given.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// -----------------------------------------------------------------------------
// spi_phase_timer
// Divides one SPI bit window into 2*CLK_DIV clk cycles. While enabled it
// counts 0 .. 2*CLK_DIV-1 and strobes on the cycle before SCK must change,
// so the registered SCK in the parent lands exactly on the phase boundary.
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   en        : high only while the parent is shifting bits
//   sck_rise  : last cycle of the low phase (SCK goes high next cycle)
//   sck_fall  : last cycle of the bit window (SCK goes low, next bit)
// -----------------------------------------------------------------------------
module spi_phase_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck_rise,
  output logic sck_fall
);

  localparam int PW = $clog2(2 * CLK_DIV);
  localparam logic [PW-1:0] RISE_AT = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] LAST    = PW'(2 * CLK_DIV - 1);

  logic [PW-1:0] phase;

  // Held at zero outside SHIFT so every frame starts on a fresh window.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      phase <= '0;
    end else if (phase == LAST) begin
      phase <= '0;
    end else begin
      phase <= phase + PW'(1);
    end
  end

  assign sck_rise = en && (phase == RISE_AT);
  assign sck_fall = en && (phase == LAST);

endmodule

// File: rtl/spi_reg_writer.sv
// -----------------------------------------------------------------------------
// spi_reg_writer
// Write-only SPI master (mode 0, MSB first) that sends one {addr, data} frame
// per chip-select assertion to the synthesizer's register bank.
// Ports:
//   clk, rst             : system clock, synchronous active-high reset
//   req_valid/req_ready  : request handshake, accepted when both are high
//   req_addr, req_data   : register address (bits [2:0]) and value
//   busy                 : a frame (including the CS-high gap) is in progress
//   done                 : one-cycle pulse on the first CS-high cycle of a frame
//   spi_mosi/sck/cs      : serial data, serial clock (idles low), chip select
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module spi_reg_writer
  import sleepy_spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int GAP      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       spi_mosi,
  output logic       spi_sck,
  output logic       spi_cs
);

  localparam int CNT_W = cnt_width(CS_SETUP, CS_HOLD, GAP);

  spi_state_t         state;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         bit_cnt;
  logic [FRAME_W-1:0] sr;
  logic               sck_rise;
  logic               sck_fall;

  spi_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (state == ST_SHIFT),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall)
  );

  // MOSI is the shift register MSB. It shifts only on an SCK fall and is
  // cleared on entry to GAP, which gives the SETUP/SHIFT/HOLD/GAP values.
  assign spi_mosi = sr[FRAME_W-1];

  // Every transition also sets the outputs for the state being entered, so
  // the outputs are registered and aligned with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      // NOTE: the shift register is reset as well: it drives MOSI directly,
      // so it must read 0 right after reset rather than leftover frame bits.
      sr        <= '0;
      spi_cs    <= 1'b1;
      spi_sck   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge register values regardless of statement order.
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            state     <= ST_SETUP;
            sr        <= {req_addr, req_data};
            cnt       <= CNT_W'(CS_SETUP - 1);
            spi_cs    <= 1'b0;
            busy      <= 1'b1;
            req_ready <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            state   <= ST_SHIFT;
            bit_cnt <= 4'd15;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_SHIFT: begin
          if (sck_rise) begin
            spi_sck <= 1'b1;
          end else if (sck_fall) begin
            spi_sck <= 1'b0;
            if (bit_cnt == 4'd0) begin
              // Last window done; MOSI keeps bit 0 through HOLD.
              state <= ST_HOLD;
              cnt   <= CNT_W'(CS_HOLD - 1);
            end else begin
              bit_cnt <= bit_cnt - 4'd1;
              sr      <= {sr[FRAME_W-2:0], 1'b0};
            end
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            state  <= ST_GAP;
            cnt    <= CNT_W'(GAP - 1);
            sr     <= '0;
            spi_cs <= 1'b1;
            done   <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt == '0) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_writer.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_writer
// Two writers share one clock: "main" with default timing (4/2/2/4) and
// "fast" with CLK_DIV=3, CS_SETUP=1, CS_HOLD=1, GAP=1. A timeline model
// predicts every output from the cycle offset since acceptance; a bus monitor
// decodes frames into a register bank like the synth's receiver would.
// -----------------------------------------------------------------------------
module tb_spi_reg_writer;
  import sleepy_spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       req_valid = 1'b0;
  logic [7:0] req_addr  = 8'h00;
  logic [7:0] req_data  = 8'h00;
  logic       req_ready, busy, done, spi_mosi, spi_sck, spi_cs;

  logic       f_req_valid = 1'b0;
  logic [7:0] f_req_addr  = 8'h00;
  logic [7:0] f_req_data  = 8'h00;
  logic       f_req_ready, f_busy, f_done, f_spi_mosi, f_spi_sck, f_spi_cs;

  int n_chk = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  spi_reg_writer #(.CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2), .GAP(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .busy(busy), .done(done),
    .spi_mosi(spi_mosi), .spi_sck(spi_sck), .spi_cs(spi_cs)
  );

  spi_reg_writer #(.CLK_DIV(3), .CS_SETUP(1), .CS_HOLD(1), .GAP(1)) dut_f (
    .clk(clk), .rst(rst),
    .req_valid(f_req_valid), .req_ready(f_req_ready),
    .req_addr(f_req_addr), .req_data(f_req_data),
    .busy(f_busy), .done(f_done),
    .spi_mosi(f_spi_mosi), .spi_sck(f_spi_sck), .spi_cs(f_spi_cs)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Timeline model. t = 1 is the first cycle after the accepting edge.
  // Returns {cs, sck, mosi, busy, done, ready}.
  // ---------------------------------------------------------------------------
  function automatic logic [5:0] exp_out(input int s, input int c, input int h,
                                         input bit act, input int t,
                                         input logic [15:0] fr);
    int   shift_end;
    int   hold_end;
    int   u;
    int   k;
    logic sck_b;
    shift_end = s + 32 * c;
    hold_end  = shift_end + h;
    if (!act)               return 6'b100001;
    if (t <= s)             return {1'b0, 1'b0, fr[15], 1'b1, 1'b0, 1'b0};
    if (t <= shift_end) begin
      u     = t - s - 1;
      k     = 15 - u / (2 * c);
      sck_b = ((u % (2 * c)) >= c);
      return {1'b0, sck_b, fr[k], 1'b1, 1'b0, 1'b0};
    end
    if (t <= hold_end)      return {1'b0, 1'b0, fr[0], 1'b1, 1'b0, 1'b0};
    return {1'b1, 1'b0, 1'b0, 1'b1, (t == hold_end + 1), 1'b0};
  endfunction

  localparam int L_M = 2 + 32 * 4 + 2 + 4;
  localparam int L_F = 1 + 32 * 3 + 1 + 1;

  bit          m_act = 1'b0, f_act = 1'b0;
  int          m_t = 0, f_t = 0;
  logic [15:0] m_fr = '0, f_fr = '0;

  always @(posedge clk) begin
    if (rst) m_act <= 1'b0;
    else if (m_act) begin
      m_t   <= m_t + 1;
      m_act <= (m_t + 1 <= L_M);
    end else if (req_valid) begin
      m_act <= 1'b1;
      m_t   <= 1;
      m_fr  <= {req_addr, req_data};
    end
  end

  always @(posedge clk) begin
    if (rst) f_act <= 1'b0;
    else if (f_act) begin
      f_t   <= f_t + 1;
      f_act <= (f_t + 1 <= L_F);
    end else if (f_req_valid) begin
      f_act <= 1'b1;
      f_t   <= 1;
      f_fr  <= {f_req_addr, f_req_data};
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_main", {spi_cs, spi_sck, spi_mosi, busy, done, req_ready},
            exp_out(2, 4, 2, m_act, m_t, m_fr));
      check("cyc_fast", {f_spi_cs, f_spi_sck, f_spi_mosi, f_busy, f_done, f_req_ready},
            exp_out(1, 3, 1, f_act, f_t, f_fr));
    end
  end

  // ---------------------------------------------------------------------------
  // Bus monitors: bit capture on SCK rise, CS timing, receiver register bank.
  // ---------------------------------------------------------------------------
  logic        p_cs = 1'b1, p_sck = 1'b0, p_mosi = 1'b0;
  int          low_len = 0, hi_len = 0, last_low = 0, last_hi = 0, rises = 0;
  int          done_cnt = 0, viol = 0, rdy_viol = 0;
  logic [15:0] word = '0;
  logic [15:0] words[$];
  logic [7:0]  rx_regs [8] = '{default: 8'h55};

  always @(negedge clk) begin
    if (chk_en) begin
      p_cs   <= spi_cs;
      p_sck  <= spi_sck;
      p_mosi <= spi_mosi;
      if (!spi_cs) low_len <= p_cs ? 1 : low_len + 1;
      if (spi_cs)  hi_len  <= p_cs ? hi_len + 1 : 1;
      if (!spi_cs && p_cs) begin
        last_hi <= hi_len;
        word    <= '0;
        rises   <= 0;
      end
      if (!spi_cs && spi_sck && !p_sck) begin
        word  <= {word[14:0], spi_mosi};
        rises <= rises + 1;
      end
      if (spi_cs && !p_cs) begin
        last_low <= low_len;
        if (rises == 16) begin
          words.push_back(word);
          if (word[15:11] == 5'd0) rx_regs[word[10:8]] <= word[7:0];
        end
      end
      if (done) done_cnt <= done_cnt + 1;
      if (spi_sck && p_sck && (spi_mosi != p_mosi)) viol <= viol + 1;
      if (!spi_cs && req_ready) rdy_viol <= rdy_viol + 1;
    end
  end

  logic        fp_cs = 1'b1, fp_sck = 1'b0, fp_mosi = 1'b0;
  int          f_low_len = 0, f_last_low = 0, f_viol = 0;
  logic [15:0] f_word = '0, f_last_word = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      fp_cs   <= f_spi_cs;
      fp_sck  <= f_spi_sck;
      fp_mosi <= f_spi_mosi;
      if (!f_spi_cs) f_low_len <= fp_cs ? 1 : f_low_len + 1;
      if (!f_spi_cs && f_spi_sck && !fp_sck) f_word <= {f_word[14:0], f_spi_mosi};
      if (f_spi_cs && !fp_cs) begin
        f_last_low  <= f_low_len;
        f_last_word <= f_word;
      end
      if (f_spi_sck && fp_sck && (f_spi_mosi != fp_mosi)) f_viol <= f_viol + 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic send(input logic [7:0] a, input logic [7:0] d, input bit keep, input bit fast);
    bit accepted;
    accepted = 1'b0;
    @(negedge clk);
    if (fast) begin
      f_req_addr = a; f_req_data = d; f_req_valid = 1'b1;
    end else begin
      req_addr = a; req_data = d; req_valid = 1'b1;
    end
    for (int n = 0; n < 2000 && !accepted; n++) begin
      if (fast ? f_req_ready : req_ready) begin
        @(posedge clk);
        #1;
        accepted = 1'b1;
        if (!keep) begin
          if (fast) f_req_valid = 1'b0;
          else      req_valid   = 1'b0;
        end
      end else begin
        @(negedge clk);
      end
    end
    check("accept", accepted, 1);
  endtask

  task automatic wait_idle(input bit fast);
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 2000 && !idle; n++) begin
      @(negedge clk);
      idle = fast ? (!f_busy && f_req_ready) : (!busy && req_ready);
    end
    #1;
    check("idle", idle, 1);
  endtask

  int done_before;
  bit hit8;

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("reset_state", {spi_cs, spi_sck, spi_mosi, busy, done, req_ready}, 6'b100001);

    // Single write, default timing
    done_before = done_cnt;
    send(8'h01, 8'hA5, 1'b0, 1'b0);
    wait_idle(1'b0);
    check("f1_count", words.size(), 1);
    check("f1_bits", words[0], 16'h01A5);
    check("f1_rises", rises, 16);
    check("f1_cs_low", last_low, 132);
    check("f1_done", done_cnt - done_before, 1);

    // Back-to-back with req_valid held high
    send(8'h05, 8'hFF, 1'b1, 1'b0);
    send(8'h00, 8'h39, 1'b0, 1'b0);
    wait_idle(1'b0);
    check("b2b_count", words.size(), 3);
    check("b2b_bits0", words[1], 16'h05FF);
    check("b2b_bits1", words[2], 16'h0039);
    check("b2b_cs_high", last_hi, 5);
    check("b2b_ready_low", rdy_viol, 0);

    // Pulse while busy is ignored; a held request goes after the gap
    send(8'h06, 8'h11, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    req_addr = 8'h07; req_data = 8'h22; req_valid = 1'b1;
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    send(8'h04, 8'h33, 1'b0, 1'b0);
    wait_idle(1'b0);
    check("pulse_count", words.size(), 5);
    check("pulse_bits0", words[3], 16'h0611);
    check("pulse_bits1", words[4], 16'h0433);

    // Reset on the 8th SCK rise
    done_before = done_cnt;
    send(8'h03, 8'hC3, 1'b0, 1'b0);
    hit8 = 1'b0;
    for (int n = 0; n < 500 && !hit8; n++) begin
      @(negedge clk);
      #1;
      hit8 = (rises == 8);
    end
    check("rst_reach8", hit8, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_outputs", {spi_cs, spi_sck, spi_mosi, done}, 4'b1000);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", req_ready, 1);
    repeat (10) @(negedge clk);
    check("rst_no_done", done_cnt - done_before, 0);
    check("rst_discard", words.size(), 5);
    send(8'h02, 8'h10, 1'b0, 1'b0);
    wait_idle(1'b0);
    check("rst_after_bits", words[5], 16'h0210);
    check("mosi_stable_main", viol, 0);

    // Minimum-timing instance
    send(8'h03, 8'h5A, 1'b0, 1'b1);
    wait_idle(1'b1);
    check("fast_cs_low", f_last_low, 98);
    check("fast_bits", f_last_word, 16'h035A);
    check("fast_mosi_stable", f_viol, 0);

    // End to end into the receiver register bank
    send(REG_CONTROL,   8'h09, 1'b0, 1'b0);
    send(REG_FREQ_LOW,  8'h00, 1'b0, 1'b0);
    send(REG_FREQ_MID,  8'h10, 1'b0, 1'b0);
    send(REG_FREQ_HIGH, 8'h00, 1'b0, 1'b0);
    send(REG_VOLUME,    8'hE0, 1'b0, 1'b0);
    wait_idle(1'b0);
    check("e2e_control",   rx_regs[REG_CONTROL[2:0]],   8'h09);
    check("e2e_freq_low",  rx_regs[REG_FREQ_LOW[2:0]],  8'h00);
    check("e2e_freq_mid",  rx_regs[REG_FREQ_MID[2:0]],  8'h10);
    check("e2e_freq_high", rx_regs[REG_FREQ_HIGH[2:0]], 8'h00);
    check("e2e_volume",    rx_regs[REG_VOLUME[2:0]],    8'hE0);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_reg_writer.md
# spi_reg_writer

SPI master that delivers single register writes to the synthesizer's SPI register bank: one 8-bit address byte followed by one 8-bit data byte per chip-select frame, mode 0, MSB first. It sits on the controller side of the link, for example in a companion sequencer or a test harness, and drives the `uio[0]` MOSI, `uio[1]` SCK and `uio[2]` CS pins of the synth. It is write-only; there is no MISO path.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per SCK phase. One bit takes 2×CLK_DIV cycles. Minimum 2.
- `CS_SETUP`, default 2: cycles with CS low and SCK low before the first bit window. Minimum 1.
- `CS_HOLD`, default 2: cycles with CS low and SCK low after the last bit window. Minimum 1.
- `GAP`, default 4: minimum cycles with CS high between frames. Minimum 1.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: synchronous reset, active high.
- `req_valid` in 1: a write request is present.
- `req_ready` out 1: the block can accept a request.
- `req_addr` in 8: register address; bits [2:0] select one of 8 registers, bits [7:3] must be 0.
- `req_data` in 8: register data.
- `busy` out 1: a frame is in progress (state ≠ IDLE).
- `done` out 1: one-cycle pulse on the first cycle CS is high after a completed frame.
- `spi_mosi` out 1: serial data.
- `spi_sck` out 1: serial clock, idles low.
- `spi_cs` out 1: chip select, active low.

## Operation
- Handshake: the request is accepted on a rising `clk` edge where `req_valid & req_ready`. `req_addr` and `req_data` are captured into a 16-bit shift register `{addr, data}`. `req_valid` while `req_ready` is low is ignored, and the requester holds the request.
- `req_ready` is 1 only in IDLE.
- FSM states and transitions:
  - IDLE → SETUP on accept.
  - SETUP → SHIFT after CS_SETUP cycles.
  - SHIFT → HOLD after 16 bit windows.
  - HOLD → GAP after CS_HOLD cycles.
  - GAP → IDLE after GAP cycles.
- SETUP: `spi_cs`=0, `spi_sck`=0, `spi_mosi`=frame bit 15.
- SHIFT, bit window k (k = 15 down to 0):
  - `spi_mosi` = bit k for the whole window.
  - `spi_sck`=0 for the first CLK_DIV cycles, then 1 for the next CLK_DIV cycles.
  - The receiver samples on the rising SCK edge. MOSI changes only together with an SCK falling edge or on entry to SETUP.
- HOLD: `spi_sck`=0, `spi_cs`=0, `spi_mosi` keeps bit 0.
- GAP: `spi_cs`=1, `spi_sck`=0, `spi_mosi`=0. `done`=1 on the first GAP cycle only.
- Counters:
  - Phase counter width is $clog2(2·CLK_DIV).
  - Bit counter is 4 bits and counts 15 down to 0.
  - Neither wraps within a frame. Terminal count moves the FSM to the next state.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset: state=IDLE, `spi_cs`=1, `spi_sck`=0, `spi_mosi`=0, `busy`=0, `done`=0, `req_ready`=1 on the first cycle after `rst` falls.
- Reset mid-frame: CS rises and SCK drops on the next edge, and there is no `done` pulse. The receiver discards the partial frame on CS rise.
- `req_addr[7:3]` ≠ 0 is transmitted unchanged and not checked; the receiver ignores such frames.

## Timing
- Accept at edge T: `spi_cs` falls and `busy` rises at T+1.
- CS low duration is exactly CS_SETUP + 32·CLK_DIV + CS_HOLD cycles. With the defaults this is 132.
- First SCK rise occurs CS_SETUP + CLK_DIV cycles after CS falls.
- The last SCK fall occurs CS_HOLD cycles before CS rises.
- `req_ready` returns GAP cycles after CS rises.
- Back-to-back requests (`req_valid` held high): CS high lasts exactly GAP+1 cycles.
- Throughput is one frame per CS_SETUP + 32·CLK_DIV + CS_HOLD + GAP + 1 cycles.
- The receiver synchronizes SCK/CS with a 2-flop synchronizer; each SCK phase must therefore span at least 3 receiver clocks. CLK_DIV ≥ 3 is required when both sides share `clk`.

## Structure
- Shared package `sleepy_spi_pkg` holds:
  - frame width (16);
  - register address constants: CONTROL=0, FREQ_LOW=1, FREQ_MID=2, FREQ_HIGH=3, DUTY=4, VOLUME=5, STREAM_SAMPLE=6, STATUS=7;
  - control bit positions: OSC_EN=0, STREAM_MODE=1, SW_GATE=2, SQUARE_EN=3, SAW_EN=4, TRI_EN=5;
  - the FSM state enum.
- One sub-module, `spi_phase_timer`: a CLK_DIV phase counter emitting `sck_rise`/`sck_fall` strobes, cleared in non-SHIFT states.
- The FSM and shift register live in the top module.

## Test plan
- Defaults, write addr 0x01 data 0xA5:
  - MOSI sampled at SCK rises = 0000_0001_1010_0101.
  - Exactly 16 rises.
  - CS low for 132 cycles.
  - One `done` pulse.
- Two back-to-back requests (0x05/0xFF then 0x00/0x39): both frames are correct, CS is high for exactly 5 cycles between them, and `req_ready` is low throughout both frames.
- `req_valid` pulsed while busy: it is ignored. Exactly one frame is sent, and the held request is sent after GAP.
- `rst` asserted on the 8th SCK rise:
  - On the next edge: CS=1, SCK=0, MOSI=0, no `done`.
  - `req_ready`=1 the cycle after `rst` falls.
  - A new write 0x02/0x10 then completes correctly.
- CLK_DIV=3, CS_SETUP=1, CS_HOLD=1, GAP=1: frame length is 98 cycles, and MOSI never changes while SCK is high.
- End-to-end with the synth's SPI receiver on a shared clock:
  - Write CONTROL=0x09, FREQ_* = 0x00/0x10/0x00, VOLUME=0xE0.
  - The register bank reads back the same values.
